tsc_multicycle_core: RTL

Multi-cycle, parametrised TSC CPU core. Fetches 16-bit TSC instructions over a request/ready instruction port, executes them with a three-state FSM, and drives WWD / register-inspection output plus a committed-instruction count. It replaces the single-cycle CPU with embedded instruction ROM; instruction storage moves outside the block.

---
 rtl/tsc_pkg.sv | 25 ++
 rtl/tsc_regfile.sv | 36 +++
 rtl/tsc_multicycle_core.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// Shared TSC definitions: opcode and function-code values and the core FSM states.
package tsc_pkg;

  localparam logic [3:0] BNE   = 4'd0;
  localparam logic [3:0] BEQ   = 4'd1;
  localparam logic [3:0] ADI   = 4'd4;
  localparam logic [3:0] ORI   = 4'd5;
  localparam logic [3:0] LHI   = 4'd6;
  localparam logic [3:0] JMP   = 4'd9;
  localparam logic [3:0] RTYPE = 4'd15;

  localparam logic [5:0] ADD = 6'd0;
  localparam logic [5:0] SUB = 6'd1;
  localparam logic [5:0] AND = 6'd2;
  localparam logic [5:0] ORR = 6'd3;
  localparam logic [5:0] WWD = 6'd28;
  localparam logic [5:0] HLT = 6'd29;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/tsc_regfile.sv
// Four-entry TSC register file: two operand read ports, one inspection read port,
// one synchronous write port, synchronous active-high clear.
module tsc_regfile
  import tsc_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [1:0]           waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [1:0]           raddr_a,
  input  logic [1:0]           raddr_b,
  input  logic [1:0]           raddr_v,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b,
  output logic [WORD_SIZE-1:0] rdata_v
);

  logic [WORD_SIZE-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads return the pre-write value, so a same-cycle write is seen one cycle later.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_v = regs[raddr_v];

endmodule

// File: rtl/tsc_multicycle_core.sv
// Multi-cycle TSC core with external instruction fetch port.
// Build macro NUM_INST_EN: defined keeps the committed-instruction counter, undefined ties num_inst to 0.
//
// state | meaning
// FETCH | request instruction at pc, latch it into ir on i_req & i_ready
// EXEC  | execute ir in one enabled cycle, write back, advance pc
// HALT  | HLT committed; only reset leaves
module tsc_multicycle_core
  import tsc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int PC_SIZE   = 8,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset_cpu,
  input  logic                 cpu_enable,
  input  logic                 wwd_enable,
  input  logic [1:0]           register_selection,
  output logic                 i_req,
  output logic [PC_SIZE-1:0]   i_addr,
  input  logic [15:0]          i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] output_port,
  output logic [7:0]           PC_below8bit,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  state_t               state;
  logic [PC_SIZE-1:0]   pc, pc_inc, pc_branch, pc_jump, pc_next;
  logic [15:0]          ir;
  logic [3:0]           op;
  logic [1:0]           rs, rt, rd;
  logic [5:0]           func;
  logic [7:0]           imm;
  logic [WORD_SIZE-1:0] rs_val, rt_val, view_val, wb_data;
  logic [1:0]           wb_addr;
  logic                 wb_en, is_wwd, is_hlt, exec_fire;

  assign op   = ir[15:12];
  assign rs   = ir[11:10];
  assign rt   = ir[9:8];
  assign rd   = ir[7:6];
  assign func = ir[5:0];
  assign imm  = ir[7:0];

  assign i_req        = (state == FETCH) && cpu_enable && !reset_cpu;
  assign i_addr       = pc;
  assign PC_below8bit = 8'(pc);
  assign exec_fire    = (state == EXEC) && cpu_enable;

  tsc_regfile #(.WORD_SIZE(WORD_SIZE)) u_regfile (
    .clk     (clk),
    .reset   (reset_cpu),
    .we      (exec_fire && wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .raddr_v (register_selection),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .rdata_v (view_val)
  );

  assign pc_inc    = pc + 1'b1;
  assign pc_branch = pc_inc + PC_SIZE'(signed'(imm));

  // Narrow PCs take the low target bits; wide PCs keep their page above bit 11.
  if (PC_SIZE <= 12) begin : g_jmp_narrow
    assign pc_jump = ir[PC_SIZE-1:0];
  end else begin : g_jmp_wide
    assign pc_jump = {pc[PC_SIZE-1:12], ir[11:0]};
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = '0;
    pc_next = pc_inc;
    is_wwd  = 1'b0;
    is_hlt  = 1'b0;
    case (op)
      RTYPE: begin
        case (func)
          ADD: begin wb_en = 1'b1; wb_data = rs_val + rt_val; end
          SUB: begin wb_en = 1'b1; wb_data = rs_val - rt_val; end
          AND: begin wb_en = 1'b1; wb_data = rs_val & rt_val; end
          ORR: begin wb_en = 1'b1; wb_data = rs_val | rt_val; end
          WWD: is_wwd = 1'b1;
          HLT: is_hlt = 1'b1;
          default: ;
        endcase
      end
      ADI: begin
        wb_en   = 1'b1;
        wb_addr = rt;
        wb_data = rs_val + WORD_SIZE'(signed'(imm));
      end
      ORI: begin
        wb_en   = 1'b1;
        wb_addr = rt;
        wb_data = rs_val | WORD_SIZE'(imm);
      end
      LHI: begin
        wb_en   = 1'b1;
        wb_addr = rt;
        wb_data = WORD_SIZE'({imm, 8'h00});
      end
      JMP: pc_next = pc_jump;
      BNE: if (rs_val != rt_val) pc_next = pc_branch;
      BEQ: if (rs_val == rt_val) pc_next = pc_branch;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state       <= FETCH;
      pc          <= PC_SIZE'(RESET_PC);
      ir          <= '0;
      output_port <= '0;
      halted      <= 1'b0;
    end else begin
      if (!wwd_enable)
        output_port <= view_val;
      else if (exec_fire && is_wwd)
        output_port <= rs_val;

      case (state)
        FETCH: begin
          if (i_req && i_ready) begin
            ir    <= i_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cpu_enable) begin
            pc <= pc_next;
            if (is_hlt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

`ifdef NUM_INST_EN
  always_ff @(posedge clk) begin
    if (reset_cpu)
      num_inst <= '0;
    else if (exec_fire)
      num_inst <= num_inst + 1'b1;
  end
`else
  assign num_inst = '0;
`endif

endmodule
